// File: rtl/rr_req_mux.sv
// rr_req_mux: requester side of a 4-way round-robin request/grant handshake.
// Four client ports are buffered in per-port FIFOs. A one-hot grant from the
// external arbiter pops the granted head entry into a single registered
// valid/ready output, which is tagged with the source port.
// Optional build macro: RR_GNT_CHECK_EN adds a sticky err_o protocol checker.
module rr_req_mux #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            in_valid_i,
    input  logic [4*DATA_W-1:0]   in_data_i,
    output logic [3:0]            in_ready_o,
    output logic [3:0]            req_o,
    input  logic [3:0]            gnt_i,
    output logic                  out_valid_o,
    output logic [DATA_W-1:0]     out_data_o,
    output logic [1:0]            out_port_o,
    input  logic                  out_ready_i
`ifdef RR_GNT_CHECK_EN
    ,
    output logic                  err_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [3:0]             fifoEmpty;
    logic [3:0]             fifoFull;
    logic [3:0]             pushEn;
    logic [3:0]             popEn;
    logic [3:0][DATA_W-1:0] headData;

    logic                   canLoad;
    logic                   gntOneHot;
    logic                   gntLegal;
    logic [1:0]             gntIdx;

    logic                   outValid_q;
    logic                   outValid_d;
    logic [DATA_W-1:0]      outData_q;
    logic [DATA_W-1:0]      outData_d;
    logic [1:0]             outPort_q;
    logic [1:0]             outPort_d;

    // The output slot can take a new word when it is empty or being drained
    // this cycle; requests are withheld otherwise so the arbiter does not
    // advance on our behalf while downstream stalls.
    assign canLoad    = !outValid_q || out_ready_i;
    assign req_o      = ~fifoEmpty & {4{canLoad && !reset}};
    assign in_ready_o = ~fifoFull & {4{!reset}};

    // A grant is honoured only when it is exactly one bit and that bit is
    // currently requested; anything else is ignored without popping.
    assign gntOneHot = (gnt_i != 4'd0) && ((gnt_i & (gnt_i - 4'd1)) == 4'd0);
    assign gntLegal  = gntOneHot && ((gnt_i & req_o) == gnt_i);
    assign popEn     = gntLegal ? gnt_i : 4'd0;

    // Encode the one-hot grant into the port index used for muxing and tagging.
    always_comb begin
        gntIdx = 2'd0;
        case (gnt_i)
            4'b0001: gntIdx = 2'd0;
            4'b0010: gntIdx = 2'd1;
            4'b0100: gntIdx = 2'd2;
            4'b1000: gntIdx = 2'd3;
            default: gntIdx = 2'd0;
        endcase
    end

    for (genvar p = 0; p < 4; p++) begin : gPort
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [AW-1:0]     wrPtr_q;
        logic [AW-1:0]     wrPtr_d;
        logic [AW-1:0]     rdPtr_q;
        logic [AW-1:0]     rdPtr_d;
        logic [CW-1:0]     count_q;
        logic [CW-1:0]     count_d;

        assign fifoEmpty[p] = (count_q == '0);
        assign fifoFull[p]  = (count_q == FULL_CNT);
        assign pushEn[p]    = in_valid_i[p] && in_ready_o[p];
        assign headData[p]  = mem_q[rdPtr_q];

        // Advance pointers on push/pop; power-of-two depth lets them wrap freely.
        always_comb begin
            wrPtr_d = wrPtr_q;
            rdPtr_d = rdPtr_q;
            count_d = count_q;
            if (pushEn[p]) begin
                wrPtr_d = wrPtr_q + AW'(1);
            end
            if (popEn[p]) begin
                rdPtr_d = rdPtr_q + AW'(1);
            end
            case ({pushEn[p], popEn[p]})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // Storage needs no reset: the count alone decides what is valid.
        always_ff @(posedge clk) begin
            if (pushEn[p]) begin
                mem_q[wrPtr_q] <= in_data_i[p*DATA_W +: DATA_W];
            end
        end

        // Pointer and occupancy registers, emptied by reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
                count_q <= '0;
            end else begin
                wrPtr_q <= wrPtr_d;
                rdPtr_q <= rdPtr_d;
                count_q <= count_d;
            end
        end
    end

    // Output slot: load on a legal grant, drop on a consumed word, else hold.
    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outPort_d  = outPort_q;
        if (gntLegal) begin
            outValid_d = 1'b1;
            outData_d  = headData[gntIdx];
            outPort_d  = gntIdx;
        end else if (outValid_q && out_ready_i) begin
            outValid_d = 1'b0;
        end
    end

    // Output register, cleared by reset so no stale word survives it.
    always_ff @(posedge clk) begin
        if (reset) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outPort_q  <= 2'd0;
        end else begin
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outPort_q  <= outPort_d;
        end
    end

    assign out_valid_o = outValid_q;
    assign out_data_o  = outData_q;
    assign out_port_o  = outPort_q;

`ifdef RR_GNT_CHECK_EN
    logic gntIllegal;
    logic err_q;
    logic err_d;

    // Flag multi-hot grants, grants to idle ports and withheld grants.
    always_comb begin
        gntIllegal = 1'b0;
        if ((gnt_i != 4'd0) && !gntOneHot) begin
            gntIllegal = 1'b1;
        end
        if ((gnt_i & ~req_o) != 4'd0) begin
            gntIllegal = 1'b1;
        end
        if ((gnt_i == 4'd0) && (req_o != 4'd0)) begin
            gntIllegal = 1'b1;
        end
        err_d = err_q || gntIllegal;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule
